// File: rtl/alu_pkg.sv
// Shared opcode and FSM state encodings for the multi-cycle ALU.
package alu_pkg;

    typedef enum logic [2:0] {
        OP_AND = 3'b000,
        OP_OR  = 3'b001,
        OP_ADD = 3'b010,
        OP_SLL = 3'b011,
        OP_MUL = 3'b100,
        OP_SRL = 3'b101,
        OP_SUB = 3'b110,
        OP_SLT = 3'b111
    } alu_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_MUL  = 2'b01,
        S_DONE = 2'b10
    } alu_state_e;

endpackage

// File: rtl/alu_mul_iter.sv
// Radix-2 shift-add multiplier: the start edge consumes bit 0, each later edge one more bit.
module alu_mul_iter #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH);

    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [CW-1:0]      cnt;

    // NOTE: sequential state uses <= so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
        end else if (start) begin
            acc    <= B[0] ? {{WIDTH{1'b0}}, A} : '0;
            mcand  <= {{(WIDTH-1){1'b0}}, A, 1'b0};
            mplier <= B >> 1;
            cnt    <= CW'(1);
        end else if (cnt != '0 && cnt != LAST) begin
            acc    <= acc + (mplier[0] ? mcand : '0);
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + CW'(1);
        end
    end

    assign done    = (cnt == LAST);
    assign product = acc;

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU with valid/ready handshakes; single-cycle ops finish in one cycle, MUL iterates.
module alu_mc
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       ALU_sel,
    input  logic [SHW-1:0]   shamt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] ALU_result,
    output logic             OF,
    output logic             busy
);

    alu_state_e         state, state_n;
    alu_op_e            op;
    logic               accept, mul_start, mul_done;
    logic [2*WIDTH-1:0] product;
    logic [WIDTH-1:0]   b_eff, sum, res;
    logic               ovf;

    assign op        = alu_op_e'(ALU_sel);
    assign accept    = in_valid && (state == S_IDLE);
    assign mul_start = accept && (op == OP_MUL);

    alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (mul_start),
        .A       (A),
        .B       (B),
        .done    (mul_done),
        .product (product)
    );

    // SUB shares the adder as A + ~B + 1.
    assign b_eff = (op == OP_SUB) ? ~B : B;
    assign sum   = A + b_eff + {{(WIDTH-1){1'b0}}, (op == OP_SUB)};

    // NOTE: every output of a combinational block gets a default first, so no latch is inferred.
    always_comb begin
        res = '0;
        ovf = 1'b0;
        case (op)
            OP_AND: res = A & B;
            OP_OR:  res = A | B;
            OP_ADD, OP_SUB: begin
                res = sum;
                ovf = (A[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
            end
            OP_SLL: res = A << shamt;
            OP_SRL: res = A >> shamt;
            OP_SLT: res = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
            default: res = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE: if (in_valid)  state_n = (op == OP_MUL) ? S_MUL : S_DONE;
            S_MUL:  if (mul_done)  state_n = S_DONE;
            S_DONE: if (out_ready) state_n = S_IDLE;
            default:               state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ALU_result <= '0;
            OF         <= 1'b0;
        end else if (accept && op != OP_MUL) begin
            ALU_result <= res;
            OF         <= ovf;
        end else if (state == S_MUL && mul_done) begin
            ALU_result <= product[WIDTH-1:0];
            OF         <= |product[2*WIDTH-1:WIDTH];
        end
    end

    assign in_ready  = (state == S_IDLE);
    assign out_valid = (state == S_DONE);
    assign busy      = (state == S_MUL);

endmodule

// File: tb/tb_alu_mc.sv
// Scoreboard bench for alu_mc at WIDTH=32, plus a WIDTH=8 instance for the narrow MUL case.
module tb_alu_mc;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        in_valid = 1'b0, out_ready = 1'b1;
    logic [31:0] A = '0, B = '0;
    logic [2:0]  ALU_sel = '0;
    logic [4:0]  shamt = '0;
    logic        in_ready, out_valid, OF, busy;
    logic [31:0] ALU_result;

    logic        in_valid8 = 1'b0, out_ready8 = 1'b1;
    logic [7:0]  A8 = '0, B8 = '0;
    logic [2:0]  ALU_sel8 = '0;
    logic [2:0]  shamt8 = '0;
    logic        in_ready8, out_valid8, OF8, busy8;
    logic [7:0]  ALU_result8;

    int          total = 0;
    int          bad = 0;
    logic [32:0] exp_q[$];

    always #5 clk = ~clk;

    alu_mc #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .ALU_sel(ALU_sel), .shamt(shamt),
        .out_valid(out_valid), .out_ready(out_ready),
        .ALU_result(ALU_result), .OF(OF), .busy(busy)
    );

    alu_mc #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
        .A(A8), .B(B8), .ALU_sel(ALU_sel8), .shamt(shamt8),
        .out_valid(out_valid8), .out_ready(out_ready8),
        .ALU_result(ALU_result8), .OF(OF8), .busy(busy8)
    );

    // Reference: {OF, result}; overflow from a 33-bit sign-extended sum/difference.
    function automatic logic [32:0] model32(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b, input logic [4:0] sh);
        logic [32:0] s;
        logic [63:0] p;
        case (op)
            3'b000: return {1'b0, a & b};
            3'b001: return {1'b0, a | b};
            3'b010: begin s = {a[31], a} + {b[31], b}; return {s[32] ^ s[31], s[31:0]}; end
            3'b110: begin s = {a[31], a} - {b[31], b}; return {s[32] ^ s[31], s[31:0]}; end
            3'b011: return {1'b0, a << sh};
            3'b101: return {1'b0, a >> sh};
            3'b111: return {1'b0, 31'b0, ($signed(a) < $signed(b))};
            default: begin p = {32'b0, a} * {32'b0, b}; return {|p[63:32], p[31:0]}; end
        endcase
    endfunction

    task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] sh, input string name);
        int lat;
        int exp_lat;
        logic [32:0] exp;
        exp_lat = (op == OP_MUL) ? 33 : 1;
        @(negedge clk);
        lat = 0;
        while (!in_ready && lat < 100) begin @(negedge clk); lat++; end
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL %s_ready: in_ready=%b wanted 1", name, in_ready);
            return;
        end
        in_valid = 1'b1; ALU_sel = op; A = a; B = b; shamt = sh;
        exp_q.push_back(model32(op, a, b, sh));
        @(negedge clk);
        in_valid = 1'b0; A = $urandom; B = $urandom; shamt = 5'($urandom);
        lat = 1;
        while (!out_valid && lat < 100) begin @(negedge clk); lat++; end
        total++;
        if (lat !== exp_lat) begin
            bad++;
            $display("FAIL %s_latency: got %0d wanted %0d", name, lat, exp_lat);
        end
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 33'h0;
        total++;
        if ({OF, ALU_result} !== exp) begin
            bad++;
            $display("FAIL %s_result: got OF=%b res=%h wanted OF=%b res=%h",
                     name, OF, ALU_result, exp[32], exp[31:0]);
        end
    endtask

    task automatic test_reset();
        #12;
        total++;
        if ({in_ready, out_valid, busy, OF, ALU_result} !== {1'b1, 3'b000, 32'h0}) begin
            bad++;
            $display("FAIL reset32: rdy=%b vld=%b busy=%b of=%b res=%h wanted 1 0 0 0 0",
                     in_ready, out_valid, busy, OF, ALU_result);
        end
        total++;
        if ({in_ready8, out_valid8, busy8, OF8, ALU_result8} !== {1'b1, 3'b000, 8'h0}) begin
            bad++;
            $display("FAIL reset8: rdy=%b vld=%b busy=%b of=%b res=%h wanted 1 0 0 0 0",
                     in_ready8, out_valid8, busy8, OF8, ALU_result8);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_single_cycle();
        do_op(OP_ADD, 32'h7FFF_FFFF, 32'h1,          5'd0,  "add_ovf_pos");
        do_op(OP_ADD, 32'h8000_0000, 32'hFFFF_FFFF,  5'd0,  "add_ovf_neg");
        do_op(OP_ADD, 32'h1234_5678, 32'h1111_1111,  5'd0,  "add_plain");
        do_op(OP_SUB, 32'd5,         32'd7,          5'd0,  "sub_neg");
        do_op(OP_SUB, 32'h8000_0000, 32'd1,          5'd0,  "sub_ovf");
        do_op(OP_SLT, 32'hFFFF_FFFF, 32'd1,          5'd0,  "slt_true");
        do_op(OP_SLT, 32'd1,         32'hFFFF_FFFF,  5'd0,  "slt_false");
        do_op(OP_AND, 32'hF0F0_FF00, 32'h0FF0_F0F0,  5'd0,  "and");
        do_op(OP_OR,  32'hF000_000F, 32'h0000_FF00,  5'd0,  "or");
        do_op(OP_SRL, 32'h8000_0001, 32'h0,          5'd31, "srl31");
        do_op(OP_SLL, 32'hDEAD_BEEF, 32'h0,          5'd4,  "sll4");
    endtask

    task automatic test_mul();
        int lat, busy_cnt, rdy_cnt;
        logic [32:0] exp;
        @(negedge clk);
        in_valid = 1'b1; ALU_sel = OP_MUL; A = 32'h1_0000; B = 32'h1_0000; shamt = '0;
        exp_q.push_back(model32(OP_MUL, 32'h1_0000, 32'h1_0000, 5'd0));
        @(negedge clk);
        lat = 1; busy_cnt = 0; rdy_cnt = 0;
        while (!out_valid && lat < 100) begin
            if (busy) busy_cnt++;
            if (in_ready) rdy_cnt++;
            in_valid = lat[0]; ALU_sel = OP_ADD; A = $urandom; B = $urandom;
            @(negedge clk);
            lat++;
        end
        in_valid = 1'b0;
        total++;
        if (lat !== 33) begin bad++; $display("FAIL mul_latency: got %0d wanted 33", lat); end
        total++;
        if (busy_cnt !== 32) begin bad++; $display("FAIL mul_busy: got %0d cycles wanted 32", busy_cnt); end
        total++;
        if (rdy_cnt !== 0) begin bad++; $display("FAIL mul_ready: got %0d ready cycles wanted 0", rdy_cnt); end
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 33'h0;
        total++;
        if ({OF, ALU_result} !== exp) begin
            bad++;
            $display("FAIL mul_result: got OF=%b res=%h wanted OF=%b res=%h", OF, ALU_result, exp[32], exp[31:0]);
        end
        @(negedge clk);
        total++;
        if ({out_valid, in_ready} !== 2'b01) begin
            bad++;
            $display("FAIL mul_ignored: vld=%b rdy=%b wanted 0 1", out_valid, in_ready);
        end
        do_op(OP_MUL, 32'd12345, 32'd6789,        5'd0, "mul_small");
        do_op(OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0, "mul_max");
    endtask

    task automatic test_stall();
        logic [32:0] exp;
        @(negedge clk);
        out_ready = 1'b0;
        in_valid = 1'b1; ALU_sel = OP_SLL; A = 32'h1; B = 32'h0; shamt = 5'd31;
        exp_q.push_back(model32(OP_SLL, 32'h1, 32'h0, 5'd31));
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = 1'b1; ALU_sel = OP_OR; A = $urandom; B = $urandom;
            total++;
            if ({out_valid, in_ready, OF, ALU_result} !== {3'b100, 32'h8000_0000}) begin
                bad++;
                $display("FAIL stall_%0d: vld=%b rdy=%b of=%b res=%h wanted 1 0 0 80000000",
                         i, out_valid, in_ready, OF, ALU_result);
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 33'h0;
        total++;
        if ({OF, ALU_result} !== exp) begin
            bad++;
            $display("FAIL stall_result: got OF=%b res=%h wanted OF=%b res=%h", OF, ALU_result, exp[32], exp[31:0]);
        end
        @(negedge clk);
        total++;
        if ({out_valid, in_ready} !== 2'b01 || exp_q.size() != 0) begin
            bad++;
            $display("FAIL stall_release: vld=%b rdy=%b pending=%0d wanted 0 1 0",
                     out_valid, in_ready, exp_q.size());
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0] op;
        for (int i = 0; i < 10; i++) begin
            op = (i == 4) ? OP_MUL : 3'($urandom_range(0, 7));
            if (op == OP_MUL && i != 4) op = OP_SUB;
            do_op(op, $urandom, $urandom, 5'($urandom), $sformatf("b2b_%0d", i));
        end
    endtask

    task automatic test_reset_mid_mul();
        int stale;
        @(negedge clk);
        in_valid = 1'b1; ALU_sel = OP_MUL; A = 32'hABCD_1234; B = 32'h5678_9ABC;
        exp_q.push_back(model32(OP_MUL, 32'hABCD_1234, 32'h5678_9ABC, 5'd0));
        @(negedge clk);
        in_valid = 1'b0;
        repeat (9) @(negedge clk);
        #2 rst_n = 1'b0;
        exp_q.delete();
        #1;
        total++;
        if ({out_valid, busy, OF, ALU_result, in_ready} !== {3'b000, 32'h0, 1'b1}) begin
            bad++;
            $display("FAIL rst_mid_mul: vld=%b busy=%b of=%b res=%h rdy=%b wanted 0 0 0 0 1",
                     out_valid, busy, OF, ALU_result, in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if ({in_ready, out_valid, busy} !== 3'b100) begin
            bad++;
            $display("FAIL rst_release: rdy=%b vld=%b busy=%b wanted 1 0 0", in_ready, out_valid, busy);
        end
        stale = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid) stale++;
        end
        total++;
        if (stale !== 0) begin bad++; $display("FAIL rst_stale: out_valid seen %0d cycles wanted 0", stale); end
        do_op(OP_ADD, 32'd100, 32'd23, 5'd0, "post_reset_add");
    endtask

    task automatic test_width8_mul();
        int lat;
        @(negedge clk);
        in_valid8 = 1'b1; ALU_sel8 = OP_MUL; A8 = 8'h0F; B8 = 8'h11;
        @(negedge clk);
        in_valid8 = 1'b0; A8 = 8'hFF; B8 = 8'hFF;
        lat = 1;
        while (!out_valid8 && lat < 100) begin @(negedge clk); lat++; end
        total++;
        if (lat !== 9) begin bad++; $display("FAIL w8_latency: got %0d wanted 9", lat); end
        total++;
        if ({OF8, ALU_result8} !== {1'b0, 8'hFF}) begin
            bad++;
            $display("FAIL w8_result: got OF=%b res=%h wanted OF=0 res=ff", OF8, ALU_result8);
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single_cycle();
        test_mul();
        test_stall();
        test_back_to_back();
        test_reset_mid_mul();
        test_width8_mul();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
